// File: rtl/uc_ctrl_if.sv
// Control bundle between microc and uc_ctrl: opcode/flag in, datapath controls out.
// With UC_PERF_CNT_EN defined the bundle also carries the 16-bit instr_count.
interface uc_ctrl_if;
  logic [5:0]  Opcode;
  logic        zero;
  logic        s_inc;
  logic        s_inm;
  logic        we;
  logic        wez;
  logic [2:0]  AluOP;
  logic        halted;
  logic        err;
`ifdef UC_PERF_CNT_EN
  logic [15:0] instr_count;
`endif

  modport master (
    output Opcode, zero,
    input  s_inc, s_inm, we, wez, AluOP, halted, err
`ifdef UC_PERF_CNT_EN
    , input instr_count
`endif
  );

  modport slave (
    input  Opcode, zero,
    output s_inc, s_inm, we, wez, AluOP, halted, err
`ifdef UC_PERF_CNT_EN
    , output instr_count
`endif
  );
endinterface

// File: rtl/uc_ctrl.sv
// Microcontroller control unit: RUN/HALT/ERR FSM plus combinational instruction decode.
// Optional retire counter (instr_count) is built only when UC_PERF_CNT_EN is defined.
module uc_ctrl (
  input  logic       clk,
  input  logic       reset,
  uc_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  localparam logic [5:0] OP_LI   = 6'b100000;
  localparam logic [5:0] OP_J    = 6'b100100;
  localparam logic [5:0] OP_JZ   = 6'b101000;
  localparam logic [5:0] OP_JNZ  = 6'b101100;
  localparam logic [5:0] OP_HALT = 6'b111111;

  state_t state_r;
  logic   halted_r;
  logic   err_r;

  logic op_alu_s;
  logic op_li_s;
  logic op_j_s;
  logic op_jz_s;
  logic op_jnz_s;
  logic op_halt_s;
  logic op_illegal_s;

  // Opcode class decode, independent of state
  always_comb begin
    op_alu_s     = ~bus.Opcode[5];
    op_li_s      = (bus.Opcode == OP_LI);
    op_j_s       = (bus.Opcode == OP_J);
    op_jz_s      = (bus.Opcode == OP_JZ);
    op_jnz_s     = (bus.Opcode == OP_JNZ);
    op_halt_s    = (bus.Opcode == OP_HALT);
    op_illegal_s = ~(op_alu_s | op_li_s | op_j_s | op_jz_s | op_jnz_s | op_halt_s);
  end

  // FSM: HALT and ERR are sticky; halted/err are registered alongside the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_RUN;
      halted_r <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (op_halt_s) begin
            state_r  <= ST_HALT;
            halted_r <= 1'b1;
            err_r    <= 1'b0;
          end else if (op_illegal_s) begin
            state_r  <= ST_ERR;
            halted_r <= 1'b1;
            err_r    <= 1'b1;
          end else begin
            state_r  <= ST_RUN;
            halted_r <= 1'b0;
            err_r    <= 1'b0;
          end
        end
        ST_HALT: begin
          state_r  <= ST_HALT;
          halted_r <= 1'b1;
          err_r    <= 1'b0;
        end
        ST_ERR: begin
          state_r  <= ST_ERR;
          halted_r <= 1'b1;
          err_r    <= 1'b1;
        end
        default: begin
          state_r  <= ST_ERR;
          halted_r <= 1'b1;
          err_r    <= 1'b1;
        end
      endcase
    end
  end

  logic       s_inc_s;
  logic       s_inm_s;
  logic       we_s;
  logic       wez_s;
  logic [2:0] alu_op_s;

  // Datapath controls: zero-latency from current state, Opcode and zero
  always_comb begin
    s_inc_s  = 1'b0;
    s_inm_s  = 1'b0;
    we_s     = 1'b0;
    wez_s    = 1'b0;
    alu_op_s = 3'b000;
    if (state_r == ST_RUN) begin
      if (op_alu_s) begin
        s_inc_s  = 1'b1;
        we_s     = 1'b1;
        wez_s    = 1'b1;
        alu_op_s = bus.Opcode[4:2];
      end else if (op_li_s) begin
        s_inc_s  = 1'b1;
        s_inm_s  = 1'b1;
        we_s     = 1'b1;
      end else if (op_jz_s) begin
        s_inc_s  = ~bus.zero;
      end else if (op_jnz_s) begin
        s_inc_s  = bus.zero;
      end else begin
        s_inc_s  = 1'b0;
      end
    end else begin
      s_inc_s  = 1'b0;
    end
  end

  // Reset suppresses architectural writes even though decode stays live
  assign bus.s_inc  = s_inc_s;
  assign bus.s_inm  = s_inm_s;
  assign bus.we     = we_s  & ~reset;
  assign bus.wez    = wez_s & ~reset;
  assign bus.AluOP  = alu_op_s;
  assign bus.halted = halted_r;
  assign bus.err    = err_r;

`ifdef UC_PERF_CNT_EN
  logic [15:0] instr_cnt_r;

  // Retire counter: every RUN cycle counts, including the HALT/illegal retire
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_cnt_r <= 16'h0000;
    end else if (state_r == ST_RUN) begin
      instr_cnt_r <= instr_cnt_r + 16'h0001;
    end else begin
      instr_cnt_r <= instr_cnt_r;
    end
  end

  assign bus.instr_count = instr_cnt_r;
`endif

endmodule

// File: tb/tb_uc_ctrl.sv
// Self-checking bench for uc_ctrl: directed table, multi-cycle sequences, random vs. model.
module tb_uc_ctrl;
  logic clk;
  logic reset;
  uc_ctrl_if bus ();

  uc_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // model: 0 = RUN, 1 = HALT, 2 = ERR
  int          m_state;
  logic [15:0] m_cnt;

  typedef struct {
    logic [5:0] op;
    logic       z;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[11];

  // {halted, err, s_inc, s_inm, we, wez, AluOP}
  function automatic logic [8:0] pk(input logic h, input logic e, input logic si,
                                    input logic sm, input logic w, input logic wz,
                                    input logic [2:0] alu);
    return {h, e, si, sm, w, wz, alu};
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    int v;
    v = int'(op);
    return (v < 32) || (v == 32) || (v == 36) || (v == 40) || (v == 44) || (v == 63);
  endfunction

  function automatic logic [8:0] model_out(input int st, input logic [5:0] op,
                                           input logic z, input logic r);
    logic [8:0] o;
    int v;
    v = int'(op);
    o = pk(st != 0, st == 2, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    if (st == 0) begin
      if (v < 32)       o[6:0] = {1'b1, 1'b0, 1'b1, 1'b1, op[4:2]};
      else if (v == 32) o[6:0] = {1'b1, 1'b1, 1'b1, 1'b0, 3'd0};
      else if (v == 40) o[6]   = ~z;
      else if (v == 44) o[6]   = z;
    end
    if (r) o[4:3] = 2'b00;
    return o;
  endfunction

  task automatic check9(input string name, input logic [8:0] act, input logic [8:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b required %b (h,e,inc,inm,we,wez,alu)", name, act, exp);
    end
  endtask

`ifdef UC_PERF_CNT_EN
  task automatic check_cnt(input string name, input logic [15:0] exp);
    vectors++;
    if (bus.instr_count !== exp) begin
      miscompares++;
      $display("FAIL %s: instr_count got %h required %h", name, bus.instr_count, exp);
    end
  endtask
`endif

  // Called 1 time unit after a rising edge: drive, compare mid-cycle, clock, update model
  task automatic step(input logic [5:0] op, input logic z, input logic r,
                      input logic [8:0] exp, input string name);
    bus.Opcode = op;
    bus.zero   = z;
    reset      = r;
    #2;
    check9(name, {bus.halted, bus.err, bus.s_inc, bus.s_inm, bus.we, bus.wez, bus.AluOP}, exp);
    @(posedge clk);
    if (r) begin
      m_state = 0;
      m_cnt   = 16'h0000;
    end else begin
      if (m_state == 0) m_cnt = m_cnt + 16'h0001;
      if (m_state == 0 && op == 6'b111111) m_state = 1;
      else if (m_state == 0 && !is_legal(op)) m_state = 2;
    end
    #1;
  endtask

  initial begin
    logic [5:0] op;
    logic       z;
    logic       r;
    int         sel;

    vectors     = 0;
    miscompares = 0;
    bus.Opcode  = 6'b000000;
    bus.zero    = 1'b0;
    reset       = 1'b1;

    tbl[0]  = '{6'b100000, 1'b0, pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000)};
    tbl[1]  = '{6'b001000, 1'b0, pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010)};
    tbl[2]  = '{6'b101000, 1'b1, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000)};
    tbl[3]  = '{6'b101000, 1'b0, pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000)};
    tbl[4]  = '{6'b101100, 1'b1, pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000)};
    tbl[5]  = '{6'b101100, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000)};
    tbl[6]  = '{6'b100100, 1'b1, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000)};
    tbl[7]  = '{6'b011111, 1'b0, pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b111)};
    tbl[8]  = '{6'b000011, 1'b1, pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b000)};
    tbl[9]  = '{6'b010100, 1'b0, pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b101)};
    tbl[10] = '{6'b100000, 1'b1, pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000)};

    @(posedge clk);
    #1;
    m_state = 0;
    m_cnt   = 16'h0000;

    // reset held: state RUN, no writes even for an ALU opcode
    step(6'b001000, 1'b0, 1'b1, pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010), "reset_alu");
    step(6'b100000, 1'b0, 1'b1, pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000), "reset_li");

    for (int i = 0; i < 11; i++)
      step(tbl[i].op, tbl[i].z, 1'b0, tbl[i].exp, $sformatf("table_%0d", i));

`ifdef UC_PERF_CNT_EN
    step(6'b000000, 1'b0, 1'b1, pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000), "cnt_reset");
    check_cnt("cnt_after_reset", 16'h0000);
    for (int i = 0; i < 5; i++)
      step(6'b000100, 1'b0, 1'b0, pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b001), "cnt_run");
    check_cnt("cnt_five", 16'h0005);
    force dut.instr_cnt_r = 16'hFFFF;
    #1;
    release dut.instr_cnt_r;
    m_cnt = 16'hFFFF;
    step(6'b000100, 1'b0, 1'b0, pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b001), "cnt_wrap_run");
    check_cnt("cnt_wrap", 16'h0000);
`endif

    // HALT: retire, then sticky with everything deasserted, reset leaves it
    step(6'b111111, 1'b0, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000), "halt_issue");
    step(6'b001000, 1'b0, 1'b0, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000), "halt_alu");
    step(6'b101000, 1'b0, 1'b0, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000), "halt_jz");
`ifdef UC_PERF_CNT_EN
    check_cnt("cnt_halt_hold", m_cnt);
`endif
    step(6'b100000, 1'b0, 1'b1, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000), "halt_reset");
    step(6'b100000, 1'b0, 1'b0, pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000), "after_halt");

    // illegal opcode traps to ERR
    step(6'b110000, 1'b0, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000), "err_issue");
    step(6'b001000, 1'b1, 1'b0, pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000), "err_alu");
    step(6'b111111, 1'b0, 1'b0, pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000), "err_halt");
    step(6'b000000, 1'b0, 1'b1, pk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000), "err_reset");
    step(6'b001000, 1'b0, 1'b0, pk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010), "after_err");

    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 50)      op = 6'($urandom_range(0, 31));
      else if (sel < 60) op = 6'b100000;
      else if (sel < 67) op = 6'b100100;
      else if (sel < 77) op = 6'b101000;
      else if (sel < 87) op = 6'b101100;
      else if (sel < 91) op = 6'b111111;
      else               op = 6'($urandom_range(32, 63));
      z = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0;
      step(op, z, r, model_out(m_state, op, z, r), $sformatf("rand_%0d", i));
`ifdef UC_PERF_CNT_EN
      check_cnt($sformatf("rand_cnt_%0d", i), m_cnt);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
